// File: rtl/dsp_sequencer_if.sv
// dsp_sequencer_if: program RAM read port between sequencer and RAM.
// The sequencer drives address/enable; the RAM returns data one cycle later.
`timescale 1ns/1ps
interface dsp_sequencer_if #(
  parameter int INSTR_WIDTH     = 26,
  parameter int PROG_ADDR_WIDTH = 10
);
  logic [PROG_ADDR_WIDTH-1:0] prog_rd_addr;
  logic                       prog_rd_en;
  logic [INSTR_WIDTH-1:0]     prog_rd_data;

  modport master (
    output prog_rd_addr,
    output prog_rd_en,
    input  prog_rd_data
  );

  modport slave (
    input  prog_rd_addr,
    input  prog_rd_en,
    output prog_rd_data
  );
endinterface

// File: rtl/dsp_sequencer.sv
// dsp_sequencer: per-frame instruction fetch/issue for dsp_core.
// Streams a straight-line program from RAM, then drains the core pipeline.
`timescale 1ns/1ps
module dsp_sequencer #(
  parameter int OPCODE_WIDTH      = 6,
  parameter int SAMPLE_ADDR_WIDTH = 10,
  parameter int PARAM_ADDR_WIDTH  = 10,
  parameter int INSTR_WIDTH       = OPCODE_WIDTH
                                  + SAMPLE_ADDR_WIDTH
                                  + PARAM_ADDR_WIDTH,
  parameter int PROG_ADDR_WIDTH   = 10,
  parameter int PIPE_DEPTH        = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     frame_start,
  input  logic [PROG_ADDR_WIDTH:0] prog_length,
  dsp_sequencer_if.master          prog,
  output logic [INSTR_WIDTH-1:0]   instruction,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun,
  input  logic                     overrun_clear
);

  localparam int LW = PROG_ADDR_WIDTH + 1;
  localparam int CW = $clog2(PIPE_DEPTH + 2);
  localparam logic [LW-1:0] MAX_LEN =
    LW'(1) << PROG_ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e                     state_q, state_d;
  logic [LW-1:0]              len_q, len_d;
  logic [PROG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                       rd_en_q, rd_en_d;
  logic                       valid_q, valid_d;
  logic [INSTR_WIDTH-1:0]     instr_q, instr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       ovr_q, ovr_d;
  logic [LW-1:0]              clamp_len;
  logic                       accept;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    rd_en_d = 1'b0;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    valid_d = rd_en_q;
    instr_d = valid_q ? prog.prog_rd_data : '0;

    clamp_len = (prog_length > MAX_LEN)
              ? MAX_LEN : prog_length;
    // A tick is welcome when idle or in the final drain cycle.
    accept = frame_start && (!busy_q || done_q);

    unique case (state_q)
      S_RUN: begin
        if ({1'b0, addr_q} == len_q - LW'(1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          addr_d  = addr_q + 1'b1;
          rd_en_d = 1'b1;
        end
      end
      S_DRAIN: begin
        cnt_d  = cnt_q + 1'b1;
        done_d = (cnt_q == CW'(PIPE_DEPTH));
        if (done_q) state_d = S_IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      if (clamp_len != '0) begin
        state_d = S_RUN;
        len_d   = clamp_len;
        addr_d  = '0;
        rd_en_d = 1'b1;
        done_d  = 1'b0;
      end else begin
        done_d  = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);

    if (frame_start && !accept) ovr_d = 1'b1;
    else if (overrun_clear)     ovr_d = 1'b0;
    else                        ovr_d = ovr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign prog.prog_rd_addr = addr_q;
  assign prog.prog_rd_en   = rd_en_q;
  assign instruction       = instr_q;
  assign busy              = busy_q;
  assign frame_done        = done_q;
  assign overrun           = ovr_q;

endmodule

// File: tb/tb_dsp_sequencer.sv
// tb_dsp_sequencer: directed bench with a frame-schedule reference model.
// Expected outputs are derived from frame start edge and length per cycle.
`timescale 1ns/1ps
module tb_dsp_sequencer;
  localparam int IW = 26;
  localparam int AW = 10;
  localparam int PD = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_start = 1'b0;
  logic [AW:0]   prog_length = '0;
  logic [IW-1:0] instruction;
  logic          busy, frame_done, overrun;
  logic          overrun_clear = 1'b0;

  dsp_sequencer_if #(.INSTR_WIDTH(IW), .PROG_ADDR_WIDTH(AW)) prog_if ();

  dsp_sequencer #(
    .OPCODE_WIDTH(6), .SAMPLE_ADDR_WIDTH(10), .PARAM_ADDR_WIDTH(10),
    .PROG_ADDR_WIDTH(AW), .PIPE_DEPTH(PD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .prog_length(prog_length), .prog(prog_if),
    .instruction(instruction), .busy(busy), .frame_done(frame_done),
    .overrun(overrun), .overrun_clear(overrun_clear)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] mem [1024];
  initial prog_if.prog_rd_data = '0;
  always @(posedge clk)
    if (prog_if.prog_rd_en) prog_if.prog_rd_data <= mem[prog_if.prog_rd_addr];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: one frame record (start edge, length) plus zero-length pulse
  int cyc = 0;
  int m_t = 0, m_l = 0, m_zero = -100;
  bit m_act = 0, m_ovr = 0;

  function automatic bit f_busy(int n);
    return m_act && n >= m_t && n < m_t + 2 + m_l + PD;
  endfunction

  function automatic bit f_done(int n);
    return (m_act && n == m_t + 1 + m_l + PD) || n == m_zero;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_act  <= 0;
      m_zero <= -100;
      m_ovr  <= 0;
    end else begin
      automatic int lc = (int'(prog_length) > 1024) ? 1024 : int'(prog_length);
      automatic bit can = !f_busy(cyc) || f_done(cyc);
      if (frame_start && can) begin
        if (lc != 0) begin
          m_t <= cyc + 1; m_l <= lc; m_act <= 1;
        end else begin
          m_zero <= cyc + 1;
        end
      end
      if (frame_start && !can) m_ovr <= 1;
      else if (overrun_clear)  m_ovr <= 0;
    end
  end

  always @(negedge clk) begin
    if (reset_n && cyc > 0) begin
      automatic int n = cyc;
      automatic int k = n - m_t - 2;
      automatic logic [IW-1:0] ei = (m_act && k >= 0 && k < m_l) ? mem[k] : '0;
      automatic bit een = m_act && n >= m_t && n < m_t + m_l;
      chk("instruction", 32'(instruction), 32'(ei));
      chk("busy", 32'(busy), 32'(f_busy(n)));
      chk("frame_done", 32'(frame_done), 32'(f_done(n)));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("prog_rd_en", 32'(prog_if.prog_rd_en), 32'(een));
      if (een) chk("prog_rd_addr", 32'(prog_if.prog_rd_addr), 32'(n - m_t));
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int len);
    @(negedge clk);
    prog_length = (AW+1)'(len);
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = IW'(i * 37 + 11);
    mem[0] = 26'h0400001;
    mem[1] = 26'h0800002;
    mem[2] = 26'h1000003;

    // reset state
    edges(2);
    chk("rst_instruction", 32'(instruction), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_rd_en", 32'(prog_if.prog_rd_en), 0);
    chk("rst_rd_addr", 32'(prog_if.prog_rd_addr), 0);
    @(negedge clk);
    reset_n = 1'b1;
    edges(2);

    // basic L=3 frame, then back-to-back at edge 10
    start_frame(3);
    chk("t1_busy_e0", 32'(busy), 1);
    edges(2);
    chk("t1_instr_e2", 32'(instruction), 32'h0400001);
    edges(2);
    chk("t1_instr_e4", 32'(instruction), 32'h1000003);
    edges(1);
    chk("t1_instr_e5", 32'(instruction), 0);
    edges(3);
    chk("t1_done_e8", 32'(frame_done), 0);
    edges(1);
    chk("t1_done_e9", 32'(frame_done), 1);
    frame_start = 1'b1;
    prog_length = 11'd3;
    edges(1);
    frame_start = 1'b0;
    chk("b2b_busy_e10", 32'(busy), 1);
    chk("b2b_overrun_e10", 32'(overrun), 0);
    edges(2);
    chk("b2b_instr_e12", 32'(instruction), 32'h0400001);
    edges(12);

    // overrun, clear, and clear+set in same edge
    start_frame(3);
    edges(3);
    frame_start = 1'b1;
    edges(1);
    frame_start = 1'b0;
    chk("ovr_set_e4", 32'(overrun), 1);
    edges(15);
    overrun_clear = 1'b1;
    edges(1);
    overrun_clear = 1'b0;
    chk("ovr_clr_e20", 32'(overrun), 0);
    start_frame(3);
    frame_start = 1'b1;
    overrun_clear = 1'b1;
    edges(1);
    frame_start = 1'b0;
    overrun_clear = 1'b0;
    chk("ovr_set_wins", 32'(overrun), 1);
    edges(12);
    overrun_clear = 1'b1;
    edges(1);
    overrun_clear = 1'b0;
    chk("ovr_clr_idle", 32'(overrun), 0);

    // zero length
    start_frame(0);
    chk("l0_done", 32'(frame_done), 1);
    chk("l0_busy", 32'(busy), 0);
    chk("l0_rd_en", 32'(prog_if.prog_rd_en), 0);
    edges(1);
    chk("l0_done_next", 32'(frame_done), 0);
    edges(2);

    // clamp 2047 -> 1024 reads, no wrap
    start_frame(2047);
    edges(1023);
    chk("clamp_addr_1023", 32'(prog_if.prog_rd_addr), 1023);
    chk("clamp_en_1023", 32'(prog_if.prog_rd_en), 1);
    edges(1);
    chk("clamp_en_off", 32'(prog_if.prog_rd_en), 0);
    chk("clamp_addr_hold", 32'(prog_if.prog_rd_addr), 1023);
    edges(1030);

    // reset mid-frame
    start_frame(8);
    edges(2);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("rstmid_instr", 32'(instruction), 0);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_done", 32'(frame_done), 0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    edges(12);
    start_frame(3);
    chk("rstmid_addr0", 32'(prog_if.prog_rd_addr), 0);
    edges(2);
    chk("rstmid_instr_e2", 32'(instruction), 32'h0400001);
    edges(10);

    // length change mid-frame has no effect
    start_frame(3);
    edges(1);
    prog_length = 11'd6;
    edges(4);
    chk("len_chg_instr_e5", 32'(instruction), 0);
    edges(4);
    chk("len_chg_done_e9", 32'(frame_done), 1);
    edges(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dsp_sequencer.md
# dsp_sequencer

Instruction sequencer directly upstream of `dsp_core`. Once per audio frame it fetches a straight-line program from a synchronous program RAM and issues one instruction word per clock on `instruction`, which drives `dsp_core.instruction`. After the last instruction it holds NOP until the core pipeline has drained, then signals frame completion. Frame ticks that arrive while a frame is still running are flagged as overruns.

## Interface
- `OPCODE_WIDTH`, default 6: opcode field width; must match the core.
- `SAMPLE_ADDR_WIDTH`, default 10: sample address field width.
- `PARAM_ADDR_WIDTH`, default 10: parameter address field width.
- `INSTR_WIDTH`, default `OPCODE_WIDTH+SAMPLE_ADDR_WIDTH+PARAM_ADDR_WIDTH`: instruction word width.
- `PROG_ADDR_WIDTH`, default 10: program RAM address width.
- `PIPE_DEPTH`, default 5: NOP cycles after the last instruction (core decode→writeback depth plus 1).

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous active-low reset.
- `frame_start` in 1: one-cycle frame tick.
- `prog_length` in `PROG_ADDR_WIDTH+1`: instruction count per frame, sampled at frame start.
- `prog_rd_addr` out `PROG_ADDR_WIDTH`: program RAM read address (registered).
- `prog_rd_en` out 1: program RAM read enable (registered).
- `prog_rd_data` in `INSTR_WIDTH`: RAM data, valid one cycle after address/enable.
- `instruction` out `INSTR_WIDTH`: to core; all-zero = NOP.
- `busy` out 1: frame in progress.
- `frame_done` out 1: one-cycle pulse in the final busy cycle.
- `overrun` out 1: sticky, set when a frame tick is rejected.
- `overrun_clear` in 1: synchronous clear of `overrun`.

## Operation
- States: IDLE, RUN, DRAIN.
- Reset (asynchronous): state IDLE; `instruction`=0, `prog_rd_addr`=0, `prog_rd_en`=0, `busy`=0, `frame_done`=0, `overrun`=0; all internal counters and the valid flag cleared.
- IDLE → RUN: `frame_start` is accepted when (`busy`=0 or `frame_done`=1) and latched length L≠0. On acceptance:
  - latch L;
  - set `prog_rd_addr`=0, `prog_rd_en`=1.
- Length handling:
  - L>2^`PROG_ADDR_WIDTH` is clamped to 2^`PROG_ADDR_WIDTH`.
  - L=0: no fetch and no `busy`; `frame_done` pulses in the next cycle.
- RUN:
  - `prog_rd_addr` increments each cycle.
  - `prog_rd_en` stays high for exactly L cycles (addresses 0..L-1). Addresses never wrap.
  - A valid flag is `prog_rd_en` delayed by one cycle.
  - Each cycle: `instruction` <= valid ? `prog_rd_data` : 0.
  - Go to DRAIN when the last read is issued.
- DRAIN:
  - `instruction`=0.
  - After the last instruction has been presented for one cycle, count `PIPE_DEPTH` NOP cycles; `frame_done` is high in the last of them.
  - Then go to IDLE. If a frame is accepted on that same edge, go to RUN instead.
- Overrun: `frame_start` sampled while `busy`=1 and `frame_done`=0 sets `overrun`; that tick is otherwise ignored. If set and `overrun_clear` occur in the same cycle, set wins.
- `prog_length` changes during a frame have no effect.
- Opcode fields are never inspected; SPIN/STORE etc. pass through unchanged.

## Timing
- Edge numbering: `frame_start` is sampled at edge T; program length is L.
- Fetch:
  - After T: `prog_rd_addr`=0, `prog_rd_en`=1, `busy`=1.
  - RAM word k appears on `prog_rd_data` after edge T+1+k.
- Issue:
  - `instruction`=P[k] during the cycle after edge T+2+k, for k=0..L-1.
  - NOP from edge T+2+L.
- Completion:
  - `frame_done` high during the cycle after edge T+1+L+`PIPE_DEPTH`.
  - `busy` falls at edge T+2+L+`PIPE_DEPTH`, unless a new frame is accepted at that edge.
- Minimum frame period: L+`PIPE_DEPTH`+2 cycles, i.e. back-to-back frames are supported with no gap.
- Reset mid-frame: `instruction` is NOP immediately (asynchronously); the interrupted frame produces no `frame_done`.

## Test plan
- L=3, P = {0x0400001, 0x0800002, 0x1000003}, `PIPE_DEPTH`=5, `frame_start` at edge 0 → `instruction` = these words during the cycles after edges 2, 3, 4; NOP after edge 5; `frame_done` only in the cycle after edge 9; `busy` falls at edge 10.
- Back-to-back: L=3, second `frame_start` at edge 10 → accepted, `overrun`=0, `busy` stays high, second program starts after edge 12.
- Overrun: `frame_start` at edges 0 and 4 (L=3) → `overrun`=1 from edge 4; first frame timing unchanged; `overrun_clear` at edge 20 → 0; clear and set in the same edge → 1.
- L=0 → no `prog_rd_en`, `busy` stays 0, `frame_done` pulses in the cycle after edge 0. L=2047 with `PROG_ADDR_WIDTH`=10 → clamped to 1024 reads, addresses 0..1023, no wrap.
- `reset_n` low at edge 3 of an L=8 frame → `instruction`=0 immediately, `busy`=0, no `frame_done`; after release, a new frame runs normally from address 0.
- Change `prog_length` 3→6 mid-frame → exactly 3 instructions issued.
